// File: rtl/fluxripper_write_pkg.sv
// fluxripper_write_pkg: shared constants, state type and rate helpers for the MFM write path
package fluxripper_write_pkg;
  localparam logic [8:0] PERIOD_250K = 9'd400;
  localparam logic [8:0] PERIOD_300K = 9'd333;
  localparam logic [8:0] PERIOD_500K = 9'd200;
  localparam logic [8:0] PERIOD_1M = 9'd100;
  localparam int MFM_SYNC_CELL = 5;
  localparam logic [7:0] FILL_BYTE = 8'h4E;
  typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;
  function automatic logic [8:0] cell_period(input logic [1:0] rate);
    return rate == 2'd0 ? PERIOD_250K : rate == 2'd1 ? PERIOD_300K :
           rate == 2'd2 ? PERIOD_500K : PERIOD_1M;
  endfunction
  // Shift is capped at a quarter cell so a shifted pulse never leaves its cell
  function automatic logic [6:0] precomp_clamp(input logic [5:0] req, input logic [8:0] period);
    logic [6:0] lim;
    lim = period[8:2];
    return {1'b0, req} > lim ? lim : {1'b0, req};
  endfunction
endpackage

// File: rtl/mfm_byte_encoder.sv
// mfm_byte_encoder: combinational MFM encode of one byte into 16 cells, MSB first
module mfm_byte_encoder
  import fluxripper_write_pkg::*;
(
  input  logic [7:0]  data,
  input  logic        prev,
  input  logic        mark,
  output logic [15:0] cells,
  output logic        next_prev
);
  logic [8:0] bits;
  assign bits = {prev, data};
  assign next_prev = data[0];
  always_comb begin
    cells = '0;
    for (int i = 0; i < 8; i++) begin
      cells[2*i+1] = ~(bits[i+1] | bits[i]);
      cells[2*i] = bits[i];
    end
    if (mark) cells[MFM_SYNC_CELL] = 1'b0;
  end
endmodule

// File: rtl/mfm_write_serializer.sv
// mfm_write_serializer: byte stream to precompensated MFM write pulses timed on clk
module mfm_write_serializer
  import fluxripper_write_pkg::*;
#(
  parameter int PULSE_W = 40
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [1:0] data_rate,
  input  logic [5:0] precomp_clks,
  input  logic [7:0] s_data,
  input  logic       s_mark,
  input  logic       s_valid,
  output logic       s_ready,
  output logic       wr_pulse,
  output logic       cell_strobe,
  output logic       busy,
  output logic       underrun
);
  state_t state;
  logic [8:0] cnt, period, target, new_period;
  logic [6:0] pc;
  logic [4:0] win;
  logic [15:0] shift, cells, width_cnt;
  logic [3:0] pos;
  logic [7:0] hold, src_data;
  logic prev, next_prev, prime_done, hold_mark, hold_full, src_mark;
  logic xfer, wrap, load, late, early, launch;
  assign s_ready = enable && state != IDLE && !hold_full;
  assign xfer = s_valid && s_ready;
  assign wrap = state != IDLE && cnt == period - 9'd1;
  assign load = wrap && pos == 4'd0;
  assign new_period = cell_period(data_rate);
  // A byte arriving on the load cycle bypasses the holding register
  assign src_data = hold_full ? hold : xfer ? s_data : FILL_BYTE;
  assign src_mark = hold_full ? hold_mark : xfer & s_mark;
  assign late = win[4] && !win[0];
  assign early = win[0] && !win[4];
  assign target = (period >> 1) + (late ? {2'b0, pc} : 9'd0) - (early ? {2'b0, pc} : 9'd0);
  assign launch = state == RUN && win[2] && cnt == target - 9'd1;
  mfm_byte_encoder u_enc (
    .data(src_data),
    .prev(prev),
    .mark(src_mark),
    .cells(cells),
    .next_prev(next_prev)
  );
  always_ff @(posedge clk) begin
    if (reset || !enable) begin
      state <= IDLE;
      cnt <= '0;
      pos <= '0;
      win <= '0;
      shift <= '0;
      prev <= 1'b0;
      prime_done <= 1'b0;
      hold <= '0;
      hold_mark <= 1'b0;
      hold_full <= 1'b0;
      width_cnt <= '0;
      wr_pulse <= 1'b0;
      cell_strobe <= 1'b0;
      busy <= 1'b0;
      underrun <= 1'b0;
      period <= new_period;
      pc <= precomp_clamp(precomp_clks, new_period);
    end else if (state == IDLE) begin
      state <= PRIME;
      busy <= 1'b1;
      period <= new_period;
      pc <= precomp_clamp(precomp_clks, new_period);
    end else begin
      cell_strobe <= wrap;
      underrun <= load && !hold_full && !xfer;
      cnt <= wrap ? 9'd0 : cnt + 9'd1;
      if (wrap) begin
        period <= new_period;
        pc <= precomp_clamp(precomp_clks, new_period);
        win <= {win[3:0], load ? cells[15] : shift[15]};
        shift <= load ? {cells[14:0], 1'b0} : {shift[14:0], 1'b0};
        pos <= pos + 4'd1;
        prime_done <= 1'b1;
        if (load) prev <= next_prev;
        if (state == PRIME && prime_done) state <= RUN;
      end
      if (load) hold_full <= 1'b0;
      else if (xfer) begin
        hold <= s_data;
        hold_mark <= s_mark;
        hold_full <= 1'b1;
      end
      if (launch) begin
        wr_pulse <= 1'b1;
        width_cnt <= 16'(PULSE_W - 1);
      end else if (width_cnt == 16'd0) wr_pulse <= 1'b0;
      else width_cnt <= width_cnt - 16'd1;
    end
  end
endmodule

// File: tb/tb_mfm_write_serializer.sv
// tb_mfm_write_serializer: directed checks of encoding, timing, precomp, underrun and abort
`timescale 1ns/1ps
module tb_mfm_write_serializer;
  logic clk = 0, reset, enable;
  logic [1:0] data_rate;
  logic [5:0] precomp_clks;
  logic [7:0] s_data;
  logic s_mark, s_valid;
  logic s_ready, wr_pulse, cell_strobe, busy, underrun;
  int n_tests = 0, n_fail = 0;
  mfm_write_serializer dut (
    .clk(clk), .reset(reset), .enable(enable), .data_rate(data_rate),
    .precomp_clks(precomp_clks), .s_data(s_data), .s_mark(s_mark), .s_valid(s_valid),
    .s_ready(s_ready), .wr_pulse(wr_pulse), .cell_strobe(cell_strobe), .busy(busy),
    .underrun(underrun)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input longint got, input longint exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask
  // byte source: main pushes {mark, data}, this process alone drives the stream
  logic [8:0] fq [0:63];
  int tail = 0;
  initial begin
    int head;
    logic took;
    head = 0;
    took = 0;
    s_valid = 0;
    s_data = 0;
    s_mark = 0;
    forever begin
      @(negedge clk);
      #1;
      if (took) head++;
      s_valid = head != tail;
      {s_mark, s_data} = s_valid ? fq[head % 64] : 9'd0;
      #1;
      took = s_valid && s_ready;
    end
  end
  task automatic push(input logic [8:0] b);
    fq[tail % 64] = b;
    tail++;
  endtask
  // observation log, cleared while the write gate is low
  int cyc = 0, nst = 0, whi = 0;
  logic wprev = 0;
  int st_cyc[$], pr_cyc[$], pr_slot[$], pr_off[$], pr_w[$], ur_slot[$];
  always @(posedge clk) begin
    #1;
    cyc++;
    if (!enable) begin
      nst = 0;
      whi = 0;
      wprev = 0;
      st_cyc.delete(); pr_cyc.delete(); pr_slot.delete(); pr_off.delete(); pr_w.delete(); ur_slot.delete();
    end else begin
      if (cell_strobe) begin
        st_cyc.push_back(cyc);
        nst++;
      end
      if (underrun) ur_slot.push_back(nst - 1);
      if (wr_pulse && !wprev) begin
        pr_cyc.push_back(cyc);
        pr_slot.push_back(nst - 1);
        pr_off.push_back(nst > 0 ? cyc - st_cyc[nst-1] : -1);
      end
      if (wr_pulse) whi++;
      else if (wprev) begin
        pr_w.push_back(whi);
        whi = 0;
      end
      wprev = wr_pulse;
    end
  end
  function automatic logic [15:0] cells_at(input int s0);
    logic [15:0] r;
    r = '0;
    foreach (pr_slot[i]) if (pr_slot[i] >= s0 && pr_slot[i] < s0 + 16) r[15 - (pr_slot[i] - s0)] = 1'b1;
    return r;
  endfunction
  function automatic int off_at(input int s);
    foreach (pr_slot[i]) if (pr_slot[i] == s) return pr_off[i];
    return -1;
  endfunction
  task automatic wait_slot(input int n, input string tag);
    int t;
    t = 0;
    while (nst < n && t < 20000) begin
      @(negedge clk);
      t++;
    end
    if (nst < n) check(tag, nst, n);
  endtask
  task automatic wait_pulse(input string tag);
    int t;
    t = 0;
    while (!wr_pulse && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (!wr_pulse) check(tag, wr_pulse, 1);
  endtask
  task automatic start(input logic [1:0] rate, input logic [5:0] pcl);
    enable = 0;
    data_rate = rate;
    precomp_clks = pcl;
    repeat (3) @(negedge clk);
  endtask
  initial begin
    int bad;
    reset = 1; enable = 1; data_rate = 2; precomp_clks = 0;
    repeat (4) @(negedge clk);
    check("rst_outs", {wr_pulse, s_ready, busy, cell_strobe, underrun}, 0);
    enable = 0;
    @(negedge clk);
    reset = 0;
    repeat (3) @(negedge clk);
    check("idle_outs", {wr_pulse, s_ready, busy, cell_strobe, underrun}, 0);
    // steady 0x00, then underrun fill, then abort mid-pulse
    start(2, 0);
    repeat (3) push(9'h000);
    enable = 1;
    #2;
    check("ready_early", s_ready, 0);
    @(posedge clk); #1;
    check("ready_rise", s_ready, 1);
    check("busy_rise", busy, 1);
    @(posedge clk); #1;
    check("ready_fall", s_ready, 0);
    wait_slot(67, "a_timeout");
    check("a_lat", pr_cyc[0] - st_cyc[0], 500);
    bad = 0;
    foreach (pr_slot[i]) if (pr_slot[i] < 50) bad++;
    check("a_cnt", bad, 24);
    bad = 0;
    for (int i = 0; i < 24; i++) if (pr_off[i] != 100) bad++;
    check("a_off", bad, 0);
    bad = 0;
    for (int i = 1; i < 24; i++) if (pr_cyc[i] - pr_cyc[i-1] != 400) bad++;
    check("a_gap", bad, 0);
    bad = 0;
    for (int i = 0; i < 24; i++) if (i >= pr_w.size() || pr_w[i] != 40) bad++;
    check("a_wid", bad, 0);
    bad = 0;
    foreach (ur_slot[i]) if (ur_slot[i] < 64) bad++;
    check("a_ur_n", bad, 1);
    check("a_ur_at", ur_slot[0], 48);
    check("a_fill", cells_at(50), 16'h9254);
    check("a_busy", busy, 1);
    wait_pulse("a_pulse_timeout");
    @(negedge clk);
    enable = 0;
    @(posedge clk); #1;
    check("ab_pulse", wr_pulse, 0);
    check("ab_ready", s_ready, 0);
    check("ab_busy", busy, 0);
    // sync mark versus plain A1, then abort with p=1 inside an 0xFF byte
    start(2, 0);
    push(9'h1A1);
    push(9'h0A1);
    push(9'h0FF);
    enable = 1;
    wait_slot(39, "b_timeout");
    check("b_mark", cells_at(2), 16'h4489);
    check("b_nomark", cells_at(18), 16'h44A9);
    check("b_ur", ur_slot.size(), 0);
    wait_pulse("b_pulse_timeout");
    @(negedge clk);
    enable = 0;
    // precompensation around a 0x00 -> 0xFF boundary, first byte also proves p restarts at 0
    start(2, 12);
    push(9'h000);
    push(9'h000);
    push(9'h0FF);
    push(9'h0FF);
    enable = 1;
    wait_slot(51, "c_timeout");
    check("c_lat", pr_cyc[0] - st_cyc[0], 488);
    check("c_late", off_at(32), 112);
    check("c_early", off_at(35), 88);
    bad = 0;
    for (int s = 37; s <= 47; s += 2) if (off_at(s) != 100) bad++;
    check("c_mid", bad, 0);
    check("c_cells", cells_at(34), 16'h5555);
    // 1M clamp to 25, then a mid-cell rate change
    start(3, 40);
    push(9'h000);
    push(9'h0FF);
    enable = 1;
    wait_slot(6, "d_timeout");
    check("d_clamp", off_at(2), 25);
    data_rate = 2;
    wait_slot(8, "d_rate_timeout");
    check("d_keep", st_cyc[6] - st_cyc[5], 100);
    check("d_new", st_cyc[7] - st_cyc[6], 200);
    enable = 0;
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mfm_write_serializer.md
# mfm_write_serializer

Write-path counterpart of the data separator. Accepts data bytes over a valid/ready stream, MFM-encodes them (including missing-clock sync marks), and times each flux transition on the system clock (200 MHz). Transitions are shifted early or late by write precompensation, then emitted as fixed-width write pulses to the drive's WRITE DATA line. Sits between the FDC write formatter and the drive interface.

## Interface
- `PULSE_W`, default 40: write pulse width in clk cycles (200 ns at 200 MHz).
- `clk`  in  1  system clock, 200 MHz.
- `reset`  in  1  synchronous, active-high reset.
- `enable`  in  1  write gate. Low forces idle and flush.
- `data_rate`  in  2  00=250K, 01=300K, 10=500K, 11=1M bps.
- `precomp_clks`  in  6  precompensation shift in clk cycles. 0 disables it.
- `s_data`  in  8  byte to write, MSB first.
- `s_mark`  in  1  with `s_data`: suppress the MFM clock at cell 5 (A1 gives 0x4489).
- `s_valid`  in  1  byte offered.
- `s_ready`  out  1  holding register empty and `enable` high.
- `wr_pulse`  out  1  flux transition pulse to the drive.
- `cell_strobe`  out  1  one-cycle pulse at every cell boundary.
- `busy`  out  1  serializer active (`enable` high and started).
- `underrun`  out  1  one-cycle pulse when a fill byte is substituted.

## Operation
- **Cell period P:** 400 / 333 / 200 / 100 clk for rates 00 / 01 / 10 / 11. One cell is half a data bit.
- **Rate changes:** `data_rate` and `precomp_clks` are sampled only at cell boundaries.
- **Buffering:** one holding register plus a 16-cell shifter. A transfer occurs when `s_valid && s_ready`.
- **Shifter load:** after the last cell (cell 0) of a byte is consumed, the shifter loads from the holding register.
- **Underrun:** if the holding register is empty at load time, the shifter loads fill byte 0x4E instead and `underrun` pulses.
- **Encoding, per data bit d with previous bit p:**
  - clock cell = ~(p | d); data cell = d.
  - p carries across bytes and resets to 0 at start.
  - When `s_mark` is set, cell index 5 (cells 15..0) is forced to 0.
- **Window:** a 5-cell look window w[4:0], where w[2] is the cell being emitted, w[4:3] are past cells and w[1:0] are future cells.
- **Precompensation:** when w[2]=1 the pulse offset is:
  - late (+pc) when w[4]=1 and w[0]=0;
  - early (−pc) when w[0]=1 and w[4]=0;
  - nominal otherwise.
  - pc = min(`precomp_clks`, P/4).
- **Pulse launch:** `wr_pulse` rises when the cell counter equals P/2 + offset and stays high for `PULSE_W` clk. Software guarantees PULSE_W < P/2 − pc.
- **State machine:**
  - IDLE → PRIME when `enable` rises.
  - PRIME lasts 2 cells, emitting no pulses while the window fills.
  - PRIME → RUN after those 2 cells.
  - Any state → IDLE when `enable` falls.
- **On `enable` low:**
  - `wr_pulse` drops the next cycle; an in-flight pulse is truncated.
  - Holding register and window are cleared and p=0.
  - `s_ready`=0 and `busy`=0.
- **Reset values:** all outputs 0, FSM in IDLE, counters 0.
- **Simultaneous events:**
  - A transfer in the same cycle as a shifter load is taken directly into the shifter; no underrun.
  - Reset has priority over enable.

## Timing
- **Accept rule:** `s_ready` rises the cycle after `enable` rises. The first byte is accepted combinationally when `s_valid` is high.
- **First byte latency:** the first byte's cell 15 occupies w[2] in the third cell slot after start, so latency is 2P + P/2 ± pc clk to the pulse, measured from the first `cell_strobe`.
- **Back-pressure:** `s_ready` falls the cycle after a transfer and rises the cycle after the shifter load.
- **Throughput:** one byte per 16P clk.
- **`cell_strobe`:** fires when the cell counter wraps P−1 → 0.
- **Pulse spacing:** successive `wr_pulse` rising edges are 2P, 3P or 4P apart, adjusted by the pc differences.

## Structure
- **Package `fluxripper_write_pkg`:**
  - cell period constants per rate;
  - `MFM_SYNC_CELL` = 5;
  - `FILL_BYTE` = 8'h4E;
  - FSM state typedef {IDLE, PRIME, RUN}.
- **Sub-module `mfm_byte_encoder`:** combinational, (byte, p, mark) → 16 cells and next p.
- **Top-level contents:** cell timer, window, precomp decision, pulse generator and handshake.

## Test plan
- **0x00 steady:** rate 10, pc 0, bytes 0x00 repeated → cells 0xAAAA; `wr_pulse` every 400 clk, width 40, no `underrun`.
- **Sync mark:** 0xA1 with `s_mark`=1 → cell pattern 0x4489. With `s_mark`=0 → 0x44A9. Check against pulse timestamps.
- **Precomp edges:** rate 10, pc 12, 0x00 then 0xFF.
  - Last 0x00 transition lands at offset 112 (late).
  - First 0xFF transition lands at offset 88 (early).
  - Interior 0xFF transitions (0x5555) land at 100.
- **Underrun:** one byte, then `s_valid` low → exactly one `underrun` pulse at the next load. The next 16 cells encode 0x4E; `busy` stays 1.
- **Abort:** `enable` dropped mid-pulse → `wr_pulse`=0 next cycle, `s_ready`=0, `busy`=0. Re-enable → 2-cell prime, then clean encoding with p=0.
- **Rate/clamp:** rate 11 with `precomp_clks`=40 → pc clamped to 25. Switching rate mid-byte changes P at the next `cell_strobe` only.
